uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares a single `uart_tx` instance (115200 baud, 434 clocks per bit at 50 MHz) between `N_REQ` byte producers.
- Issues one byte at a time to the transmitter and waits for its done pulse.
- Supports a per-requester lock so multi-byte messages are not interleaved with other requesters' bytes.
- Recovers from a missing done pulse with a watchdog timeout.
- Sits between the producer logic and the `uart` wrapper's `i_tx_byte_rdy`/`i_tx_byte`/`o_tx_busy`/`o_tx_done` ports.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CLKS`, default 8192: watchdog limit in clocks from issue to done. This must exceed one frame, 10 × 434 = 4340 clocks.
- `i_clk`  in  1  system clock. The block has one clock.
- `i_reset`  in  1  reset, synchronous and active-high.
- `i_req_valid`  in  N_REQ  per-requester byte-pending flag. It must stay high, with the byte stable, until the matching ack.
- `i_req_byte`  in  8*N_REQ  per-requester byte. Requester k drives bits [8k+7:8k].
- `i_req_lock`  in  N_REQ  requester wants to keep ownership after its current byte.
- `o_req_ack`  out  N_REQ  one-cycle pulse: byte accepted and issued to the UART.
- `o_grant`  out  N_REQ  one-hot current/last owner. It is zero when no owner is held.
- `o_tx_byte_rdy`  out  1  one-cycle start pulse to `uart_tx`.
- `o_tx_byte`  out  8  byte to `uart_tx`. It is held stable from issue until return to IDLE.
- `i_tx_busy`  in  1  `uart_tx` busy.
- `i_tx_done`  in  1  `uart_tx` frame-complete pulse.
- `o_active`  out  1  high while in SEND.
- `o_timeout`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- The FSM has two states, IDLE and SEND.
- **Candidate set, evaluated in IDLE:**
  - If an owner is held and `i_req_lock[owner]` is high, the candidate set is {owner} only.
  - Otherwise all requesters are candidates.
- **Round-robin selection:**
  - A pointer `rr` holds the index searched first.
  - Select the first valid candidate at index `rr`, `rr+1`, … modulo `N_REQ`.
  - After each issue, `rr` = selected index + 1 mod `N_REQ`.
- **IDLE → SEND** happens when the following are true in the same cycle:
  - at least one valid candidate exists;
  - `i_tx_busy` = 0;
  - not in reset.
- **On the transition to SEND** the following are registered so they are visible in the next cycle:
  - `o_tx_byte` = the selected requester's byte;
  - `o_tx_byte_rdy` = 1;
  - `o_req_ack[g]` = 1;
  - `o_grant` = one-hot(g);
  - the watchdog counter is cleared.
- **In SEND:**
  - The counter increments every cycle.
  - `i_req_valid` and `i_req_lock` are ignored.
  - If `i_tx_done` = 1, go to IDLE. The owner is held only if `i_req_lock[g]` is high in that cycle; otherwise the owner is released (`o_grant` → 0).
  - Else, if the counter reaches `TIMEOUT_CLKS-1`, pulse `o_timeout`, go to IDLE, and release the owner unconditionally.
- **Lock release:**
  - A held owner that drops `i_req_lock` while in IDLE is released in that same cycle.
  - In that case normal round-robin applies to the same-cycle selection.
  - A held owner with lock high but valid low keeps the UART idle. All other requesters stall. This is by design.
- **Counter width:** clog2(`TIMEOUT_CLKS`). It saturates and never wraps.

## Timing
- **Reset values:**
  - State IDLE.
  - `o_req_ack`, `o_grant`, `o_tx_byte_rdy`, `o_tx_byte`, `o_active`, `o_timeout` = 0.
  - `rr` = 0, so requester 0 wins first.
  - Owner is released and the counter = 0.
- **Reset mid-SEND:** the block returns to IDLE and drops ownership. Because `uart_tx` is not reset by this block, no new issue occurs until `i_tx_busy` = 0.
- **Issue latency:** valid is seen in IDLE at cycle t → `o_tx_byte_rdy` and `o_req_ack` are high at cycle t+1, for exactly one cycle.
- **Back-to-back issue:** `i_tx_done` at cycle d → IDLE at d+1 → next `o_tx_byte_rdy` at d+2 at the earliest.
- **Ack cycle:** the requester may update its byte and valid in the ack cycle. The next value is sampled no earlier than the return to IDLE.
- **Simultaneous done and timeout:** done takes priority, and no `o_timeout` pulse is produced.
- **Stray `i_tx_done` in IDLE:** ignored.

## Test plan
- **Single request:** reset, then requester 2 valid with 0xA5 → ack[2] and tx_byte_rdy at the same cycle, exactly 1 cycle wide, one cycle after valid; `o_tx_byte`=0xA5; `o_grant`=0b0100 until done; next issue ≥ done+2.
- **Round-robin fairness:** all 4 requesters continuously valid with bytes 0x10..0x13, loopback UART model → issue order 0,1,2,3,0,1… and 8 acks covering each requester twice.
- **Lock:**
  - Requester 1 holds lock for 3 bytes (0x41,0x42,0x43) while requesters 0 and 3 are valid → the three bytes are consecutive on the wire.
  - Lock drops before the 4th byte → next grant goes to 2/3/0 per the pointer, never 1 twice.
- **Timeout:** `TIMEOUT_CLKS`=64; the model never pulses done → `o_timeout` pulse at issue+64; `o_grant` → 0; IDLE; next request is served normally.
- **Busy gating and reset mid-frame:**
  - Hold `i_tx_busy`=1 with requests pending → no issue.
  - Assert `i_reset` during SEND → all outputs 0 the next cycle.
  - After busy clears, requester 0 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one uart_tx among N_REQ byte producers, with per-requester lock and a done watchdog.
// Issue lands one cycle after a valid candidate is seen in IDLE; one byte in flight, stalls on i_tx_busy or a locked-but-idle owner.
module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int TIMEOUT_CLKS = 8192
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [N_REQ-1:0]   i_req_valid,
   input  logic [8*N_REQ-1:0] i_req_byte,
   input  logic [N_REQ-1:0]   i_req_lock,
   output logic [N_REQ-1:0]   o_req_ack,
   output logic [N_REQ-1:0]   o_grant,
   output logic               o_tx_byte_rdy,
   output logic [7:0]         o_tx_byte,
   input  logic               i_tx_busy,
   input  logic               i_tx_done,
   output logic               o_active,
   output logic               o_timeout
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT_CLKS);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CLKS - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state;
   logic [IW-1:0]    rr;
   logic [IW-1:0]    owner;
   logic             owner_vld;
   logic [CW-1:0]    wd_cnt;

   logic             held;
   logic             sel_found;
   logic [IW-1:0]    sel_idx;
   logic [IW-1:0]    idx;
   logic [7:0]       sel_byte;
   logic [N_REQ-1:0] sel_oh;

   // A locked owner narrows the candidate set to itself; otherwise search from rr.
   always_comb begin
      held      = owner_vld && i_req_lock[owner];
      sel_found = 1'b0;
      sel_idx   = '0;
      idx       = '0;
      if (held) begin
         sel_found = i_req_valid[owner];
         sel_idx   = owner;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (int'(rr) + i >= N_REQ)
               idx = IW'(int'(rr) + i - N_REQ);
            else
               idx = IW'(int'(rr) + i);
            if (!sel_found && i_req_valid[idx]) begin
               sel_found = 1'b1;
               sel_idx   = idx;
            end
         end
      end
      sel_byte = '0;
      sel_oh   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel_idx == IW'(i)) begin
            sel_byte  = i_req_byte[8*i +: 8];
            sel_oh[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= IDLE;
         rr            <= '0;
         owner         <= '0;
         owner_vld     <= 1'b0;
         wd_cnt        <= '0;
         o_req_ack     <= '0;
         o_grant       <= '0;
         o_tx_byte_rdy <= 1'b0;
         o_tx_byte     <= '0;
         o_active      <= 1'b0;
         o_timeout     <= 1'b0;
      end else begin
         o_req_ack     <= '0;
         o_tx_byte_rdy <= 1'b0;
         o_timeout     <= 1'b0;
         case (state)
            IDLE: begin
               if (owner_vld && !held) begin
                  owner_vld <= 1'b0;
                  o_grant   <= '0;
               end
               if (sel_found && !i_tx_busy) begin
                  state         <= SEND;
                  o_active      <= 1'b1;
                  o_tx_byte     <= sel_byte;
                  o_tx_byte_rdy <= 1'b1;
                  o_req_ack     <= sel_oh;
                  o_grant       <= sel_oh;
                  owner         <= sel_idx;
                  owner_vld     <= 1'b1;
                  wd_cnt        <= '0;
                  rr            <= (sel_idx == IDX_LAST) ? '0 : sel_idx + 1'b1;
               end
            end
            SEND: begin
               if (wd_cnt != '1)
                  wd_cnt <= wd_cnt + 1'b1;
               // Done wins over a coincident watchdog expiry.
               if (i_tx_done) begin
                  state    <= IDLE;
                  o_active <= 1'b0;
                  if (!i_req_lock[owner]) begin
                     owner_vld <= 1'b0;
                     o_grant   <= '0;
                  end
               end else if (wd_cnt == CNT_LAST) begin
                  o_timeout <= 1'b1;
                  state     <= IDLE;
                  o_active  <= 1'b0;
                  owner_vld <= 1'b0;
                  o_grant   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, loopback uart_tx model and an issue-order scoreboard.
module tb_uart_tx_arbiter;
   localparam int N     = 4;
   localparam int TO    = 64;
   localparam int FRAME = 12;
   localparam int DEPTH = 16;

   typedef struct packed {
      logic [1:0] idx;
      logic [7:0] dat;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_lock = '0;
   logic [8*N-1:0] req_byte = '0;
   logic           tx_busy = 1'b0;
   logic           tx_done = 1'b0;
   logic [N-1:0]   req_ack;
   logic [N-1:0]   grant;
   logic           tx_rdy;
   logic [7:0]     tx_byte;
   logic           active;
   logic           timeout;

   uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CLKS(TO)) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_req_valid   (req_valid),
      .i_req_byte    (req_byte),
      .i_req_lock    (req_lock),
      .o_req_ack     (req_ack),
      .o_grant       (grant),
      .o_tx_byte_rdy (tx_rdy),
      .o_tx_byte     (tx_byte),
      .i_tx_busy     (tx_busy),
      .i_tx_done     (tx_done),
      .o_active      (active),
      .o_timeout     (timeout)
   );

   initial forever #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   logic [7:0] rbuf [N][DEPTH];
   int   rhead[N] = '{default: 0};
   int   rtail[N] = '{default: 0};
   int   lock_left[N] = '{default: 0};
   int   ack_cnt[N] = '{default: 0};
   logic model_busy = 1'b0;
   logic force_busy = 1'b0;
   logic mute = 1'b0;
   logic busy_seen = 1'b0;
   int   frame_cnt = 0;
   int   last_done = -1;
   int   last_issue = 0;
   int   issue_cnt = 0;
   int   to_cnt = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor, requester drivers and uart_tx model all act on the falling edge.
   initial forever begin
      exp_t e;
      logic [N-1:0] oh;
      @(negedge clk);
      if (tx_rdy) begin
         issue_cnt++;
         last_issue = cyc;
         for (int k = 0; k < N; k++) if (req_ack[k]) ack_cnt[k]++;
         chk("issue_while_busy", {31'b0, busy_seen}, 32'd0);
         if (last_done >= 0) begin
            chk("done_to_issue_gap", {31'b0, (cyc - last_done >= 2)}, 32'd1);
            last_done = -1;
         end
         chk("issue_expected", {31'b0, (exp_q.size() != 0)}, 32'd1);
         if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            oh = '0;
            oh[e.idx] = 1'b1;
            chk("sb_ack", {28'b0, req_ack}, {28'b0, oh});
            chk("sb_grant", {28'b0, grant}, {28'b0, oh});
            chk("sb_byte", {24'b0, tx_byte}, {24'b0, e.dat});
         end
      end
      if (timeout) to_cnt++;
      for (int k = 0; k < N; k++) begin
         if (req_ack[k]) begin
            rhead[k]++;
            if (lock_left[k] > 0) lock_left[k]--;
         end
         req_valid[k]        = rhead[k] < rtail[k];
         req_byte[8*k +: 8]  = (rhead[k] < rtail[k]) ? rbuf[k][rhead[k]] : 8'h00;
         req_lock[k]         = lock_left[k] > 0;
      end
      tx_done = 1'b0;
      if (frame_cnt > 0) begin
         frame_cnt--;
         if (frame_cnt == 0) begin
            model_busy = 1'b0;
            if (!mute) begin
               tx_done = 1'b1;
               if (active) last_done = cyc;
            end
         end
      end
      if (tx_rdy) begin
         model_busy = 1'b1;
         frame_cnt  = FRAME;
      end
      tx_busy   = model_busy | force_busy;
      busy_seen = tx_busy;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push_req(input int k, input logic [7:0] b);
      rbuf[k][rtail[k]] = b;
      rtail[k]++;
   endtask

   task automatic expect_issue(input int k, input logic [7:0] b);
      exp_t e;
      e.idx = 2'(k);
      e.dat = b;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string tag, input int max);
      int n = 0;
      while (!(exp_q.size() == 0 && !active && !model_busy && !tx_rdy) && n < max) begin
         step();
         n++;
      end
      chk(tag, {31'b0, (exp_q.size() == 0 && !active)}, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      int n0;
      int a0[N];
      repeat (3) @(posedge clk);
      step();
      chk("rst_ack", {28'b0, req_ack}, 32'd0);
      chk("rst_grant", {28'b0, grant}, 32'd0);
      chk("rst_rdy", {31'b0, tx_rdy}, 32'd0);
      chk("rst_byte", {24'b0, tx_byte}, 32'd0);
      chk("rst_active", {31'b0, active}, 32'd0);
      chk("rst_timeout", {31'b0, timeout}, 32'd0);
      rst = 1'b0;

      // Single request from requester 2
      push_req(2, 8'hA5);
      expect_issue(2, 8'hA5);
      step();
      chk("t1_valid_up", {31'b0, req_valid[2]}, 32'd1);
      chk("t1_no_early_rdy", {31'b0, tx_rdy}, 32'd0);
      step();
      chk("t1_rdy", {31'b0, tx_rdy}, 32'd1);
      chk("t1_ack", {28'b0, req_ack}, 32'h4);
      step();
      chk("t1_rdy_1cyc", {31'b0, tx_rdy}, 32'd0);
      chk("t1_ack_1cyc", {28'b0, req_ack}, 32'd0);
      chk("t1_grant", {28'b0, grant}, 32'h4);
      chk("t1_active", {31'b0, active}, 32'd1);
      chk("t1_byte", {24'b0, tx_byte}, 32'hA5);
      n = 0;
      while (!tx_done && n < 100) begin step(); n++; end
      chk("t1_done_seen", {31'b0, tx_done}, 32'd1);
      chk("t1_grant_until_done", {28'b0, grant}, 32'h4);
      step();
      chk("t1_idle_after_done", {31'b0, active}, 32'd0);
      chk("t1_grant_released", {28'b0, grant}, 32'd0);
      drain("t1_drain", 200);

      // Round-robin with all four continuously valid
      do_reset();
      for (int k = 0; k < N; k++) a0[k] = ack_cnt[k];
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < N; k++) begin
            push_req(k, 8'h10 + 8'(k));
            expect_issue(k, 8'h10 + 8'(k));
         end
      drain("t2_drain", 600);
      for (int k = 0; k < N; k++)
         chk($sformatf("t2_acks_req%0d", k), ack_cnt[k] - a0[k], 32'd2);

      // Lock: requester 1 sends three bytes back-to-back, then yields
      push_req(0, 8'h30);
      push_req(0, 8'h50);
      push_req(1, 8'h41);
      push_req(1, 8'h42);
      push_req(1, 8'h43);
      push_req(1, 8'h44);
      push_req(3, 8'h53);
      lock_left[1] = 3;
      expect_issue(0, 8'h30);
      expect_issue(1, 8'h41);
      expect_issue(1, 8'h42);
      expect_issue(1, 8'h43);
      expect_issue(3, 8'h53);
      expect_issue(0, 8'h50);
      expect_issue(1, 8'h44);
      drain("t3_drain", 800);

      // Watchdog: model withholds done
      mute = 1'b1;
      push_req(2, 8'h77);
      expect_issue(2, 8'h77);
      n = 0;
      while (!timeout && n < 300) begin step(); n++; end
      chk("t4_timeout_seen", {31'b0, timeout}, 32'd1);
      chk("t4_timeout_latency", cyc - last_issue, 32'd64);
      chk("t4_grant_released", {28'b0, grant}, 32'd0);
      chk("t4_idle", {31'b0, active}, 32'd0);
      step();
      chk("t4_timeout_1cyc", {31'b0, timeout}, 32'd0);
      mute = 1'b0;
      push_req(3, 8'h88);
      expect_issue(3, 8'h88);
      drain("t4_drain", 200);

      // Busy gating, then reset mid-frame
      force_busy = 1'b1;
      push_req(2, 8'h62);
      n0 = issue_cnt;
      repeat (20) step();
      chk("t5_no_issue_busy", issue_cnt, n0);
      chk("t5_idle_busy", {31'b0, active}, 32'd0);
      expect_issue(2, 8'h62);
      force_busy = 1'b0;
      n = 0;
      while (issue_cnt == n0 && n < 100) begin step(); n++; end
      chk("t5_issue_after_busy", issue_cnt, n0 + 1);
      step();
      step();
      chk("t5_in_send", {31'b0, active}, 32'd1);
      rst = 1'b1;
      push_req(0, 8'h60);
      push_req(2, 8'h63);
      expect_issue(0, 8'h60);
      expect_issue(2, 8'h63);
      step();
      chk("t5_rst_outputs", {18'b0, req_ack, grant, tx_rdy, tx_byte, active, timeout}, 32'd0);
      rst = 1'b0;
      drain("t5_drain", 300);

      chk("timeout_count", to_cnt, 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
